// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ovs
// Brief    : Oversampled UART receiver, 3-sample majority vote, optional
//            parity, 1/2 stop bits, one-deep AXIS holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ovs #(
    parameter int CLKS_PER_SAMPLE = 5,
    parameter int OVERSAMPLE      = 16,
    parameter int FRAME_WIDTH     = 64,
    parameter int PARITY_MODE     = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [FRAME_WIDTH-1:0] m_axis_rx_tdata,
    output logic [1:0]             m_axis_rx_tuser,
    output logic                   m_axis_rx_tvalid,
    input  logic                   m_axis_rx_tready,
    output logic                   overrun,
    output logic                   busy
);

    localparam int TW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(FRAME_WIDTH + 1);

    localparam logic [TW-1:0] c_tick_last = TW'(CLKS_PER_SAMPLE - 1);
    localparam logic [SW-1:0] c_s_last    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] c_s_a       = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] c_s_b       = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] c_s_dec     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [IW-1:0] c_idx_last  = IW'(FRAME_WIDTH - 1);
    localparam logic          c_stop_last = (STOP_BITS == 2);
    localparam logic          c_odd       = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 r_state;
    logic                   r_sync1, r_sync2;
    logic                   r_busy;
    logic [TW-1:0]          r_tcnt;
    logic [SW-1:0]          r_s;
    logic                   r_smp_a, r_smp_b;
    logic [IW-1:0]          r_idx;
    logic                   r_stop_idx;
    logic [FRAME_WIDTH-1:0] r_data;
    logic                   r_perr, r_ferr;

    logic [FRAME_WIDTH-1:0] r_tdata;
    logic [1:0]             r_tuser;
    logic                   r_tvalid;
    logic                   r_overrun;

    logic                   w_rxs;
    logic                   w_tick;
    logic [SW-1:0]          w_s_next;
    logic                   w_wrap;
    logic                   w_dec;
    logic                   w_bit;
    logic                   w_ferr;
    logic                   w_done;
    logic [FRAME_WIDTH-1:0] w_shift;

    assign w_rxs    = r_sync2;
    assign w_tick   = (r_state != S_IDLE) && (r_tcnt == c_tick_last);
    assign w_s_next = (r_s == c_s_last) ? '0 : r_s + 1'b1;
    assign w_wrap   = w_tick && (r_s == c_s_last);
    // The third vote sample is the live synchronised line at the decision tick.
    assign w_dec    = w_tick && (w_s_next == c_s_dec);
    assign w_bit    = (r_smp_a & r_smp_b) | (r_smp_a & w_rxs) | (r_smp_b & w_rxs);
    assign w_ferr   = r_ferr | ~w_bit;
    assign w_done   = (r_state == S_STOP) && w_dec && (r_stop_idx == c_stop_last);

    generate
        if (FRAME_WIDTH == 1) begin : g_shift_1
            assign w_shift = w_bit;
        end else begin : g_shift_n
            assign w_shift = {w_bit, r_data[FRAME_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_tcnt     <= '0;
            r_s        <= '0;
            r_smp_a    <= 1'b1;
            r_smp_b    <= 1'b1;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_data     <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;

            if (r_state == S_IDLE) begin
                r_tcnt <= '0;
                r_s    <= '0;
            end else begin
                r_tcnt <= w_tick ? '0 : r_tcnt + 1'b1;
                if (w_tick) r_s <= w_s_next;
            end

            if (w_tick && (w_s_next == c_s_a)) r_smp_a <= w_rxs;
            if (w_tick && (w_s_next == c_s_b)) r_smp_b <= w_rxs;

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state    <= S_START;
                        r_busy     <= 1'b1;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_stop_idx <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_dec && w_bit) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_wrap) begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_dec) r_data <= w_shift;
                    if (w_wrap) begin
                        if (r_idx == c_idx_last) begin
                            if (PARITY_MODE != 0) r_state <= S_PARITY;
                            else                  r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_dec)  r_perr  <= ((^r_data) ^ w_bit) != c_odd;
                    if (w_wrap) r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_dec) begin
                        r_ferr <= w_ferr;
                        // Leave at the final decision; the stop-bit tail is not waited out.
                        if (r_stop_idx == c_stop_last) begin
                            if (w_ferr) begin
                                r_state <= S_BREAK;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    if (w_wrap) r_stop_idx <= 1'b1;
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // One-deep holding register: a frame completing against a stalled slot is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdata   <= '0;
            r_tuser   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_tvalid || m_axis_rx_tready) begin
                    r_tdata  <= r_data;
                    r_tuser  <= {w_ferr, r_perr};
                    r_tvalid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (m_axis_rx_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_rx_tdata  = r_tdata;
    assign m_axis_rx_tuser  = r_tuser;
    assign m_axis_rx_tvalid = r_tvalid;
    assign overrun          = r_overrun;
    assign busy             = r_busy;

endmodule
`default_nettype wire
